// File: rtl/bram_frame_writer.sv
// rtl/bram_frame_writer.sv - raster-order RGB565 stream to video BRAM port A writer
module bram_frame_writer #(
  parameter int HSIZE  = 640,
  parameter int VSIZE  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              PIX_VALID,
  output logic              PIX_READY,
  input  logic [15:0]       PIX_DATA,
  input  logic              PIX_SOF,
  input  logic              REVERSE,
  output logic              BRAMWE,
  output logic [ADDR_W-1:0] BRAMADDR,
  output logic [15:0]       BRAMDIN,
  output logic [13:0]       hcnt,
  output logic [ADDR_W-1:0] vcnt,
  output logic              FRAME_DONE,
  output logic              SYNC_ERR
);

  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((VSIZE - 1) * HSIZE);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(HSIZE);
  localparam logic [13:0]       LAST_COL  = 14'(HSIZE - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state;
  logic              rev_q;

  logic              xfer;
  logic              sof_xfer;
  logic              accept;
  logic              pos_rev;
  logic [13:0]       pos_h;
  logic [ADDR_W-1:0] pos_v;
  logic [ADDR_W-1:0] first_v;
  logic [ADDR_W-1:0] final_v;
  logic [ADDR_W-1:0] next_v;
  logic [ADDR_W-1:0] wr_addr;
  logic              row_end;
  logic              frame_end;

  // The DONE bubble is the only cycle the writer refuses pixels.
  assign PIX_READY = (state != DONE);

  // Position of the pixel being transferred: an SOF always restarts at column 0
  // of the first row for the freshly sampled mode, otherwise the counters apply.
  always_comb begin
    xfer      = PIX_VALID && PIX_READY;
    sof_xfer  = xfer && PIX_SOF;
    accept    = xfer && ((state == WRITE) || PIX_SOF);
    pos_rev   = sof_xfer ? REVERSE : rev_q;
    pos_h     = sof_xfer ? 14'd0 : hcnt;
    pos_v     = vcnt;
    if (sof_xfer) begin
      pos_v = REVERSE ? LAST_BASE : '0;
    end
    first_v   = pos_rev ? LAST_BASE : '0;
    final_v   = pos_rev ? '0 : LAST_BASE;
    next_v    = pos_rev ? (pos_v - ROW_STEP) : (pos_v + ROW_STEP);
    wr_addr   = pos_v + ADDR_W'(pos_h);
    row_end   = (pos_h == LAST_COL);
    frame_end = row_end && (pos_v == final_v);
  end

  // Frame FSM with registered BRAM port, counters and status pulses.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      rev_q      <= 1'b0;
      BRAMWE     <= 1'b0;
      BRAMADDR   <= '0;
      BRAMDIN    <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      FRAME_DONE <= 1'b0;
      SYNC_ERR   <= 1'b0;
    end else begin
      BRAMWE     <= accept;
      FRAME_DONE <= accept && frame_end;
      SYNC_ERR   <= (state == WRITE) && sof_xfer;
      if (accept) begin
        BRAMADDR <= wr_addr;
        BRAMDIN  <= PIX_DATA;
        rev_q    <= pos_rev;
        if (frame_end) begin
          hcnt  <= '0;
          vcnt  <= first_v;
          state <= DONE;
        end else if (row_end) begin
          hcnt  <= '0;
          vcnt  <= next_v;
          state <= WRITE;
        end else begin
          hcnt  <= pos_h + 14'd1;
          vcnt  <= pos_v;
          state <= WRITE;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_bram_frame_writer.sv
// tb/tb_bram_frame_writer.sv - scoreboard bench for bram_frame_writer
module tb_bram_frame_writer;

  localparam int HS = 4;
  localparam int VS = 3;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        PIX_VALID = 1'b0;
  logic        PIX_READY;
  logic [15:0] PIX_DATA = 16'h0;
  logic        PIX_SOF = 1'b0;
  logic        REVERSE = 1'b0;
  logic        BRAMWE;
  logic [3:0]  BRAMADDR;
  logic [15:0] BRAMDIN;
  logic [13:0] hcnt;
  logic [3:0]  vcnt;
  logic        FRAME_DONE;
  logic        SYNC_ERR;

  bram_frame_writer #(.HSIZE(HS), .VSIZE(VS), .ADDR_W(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .PIX_DATA(PIX_DATA), .PIX_SOF(PIX_SOF), .REVERSE(REVERSE), .BRAMWE(BRAMWE),
    .BRAMADDR(BRAMADDR), .BRAMDIN(BRAMDIN), .hcnt(hcnt), .vcnt(vcnt),
    .FRAME_DONE(FRAME_DONE), .SYNC_ERR(SYNC_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic        done;
    logic        sync;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   n_writes = 0;
  int   n_done = 0;
  int   n_sync = 0;

  bit   m_active = 0;
  bit   m_rev = 0;
  int   m_col = 0;
  int   m_row = 0;

  // Output monitor: every write must match the oldest expected entry.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (BRAMWE) begin
        n_writes++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got addr=%0d data=%h exp no write", BRAMADDR, BRAMDIN);
        end else begin
          mon_e = sb.pop_front();
          if ({BRAMADDR, BRAMDIN, FRAME_DONE, SYNC_ERR} !== {mon_e.addr, mon_e.data, mon_e.done, mon_e.sync}) begin
            failures++;
            $display("FAIL write got addr=%0d data=%h done=%b sync=%b exp addr=%0d data=%h done=%b sync=%b",
                     BRAMADDR, BRAMDIN, FRAME_DONE, SYNC_ERR, mon_e.addr, mon_e.data, mon_e.done, mon_e.sync);
          end
        end
      end else if (FRAME_DONE !== 1'b0 || SYNC_ERR !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL stray_pulse got done=%b sync=%b exp 0 0 without write", FRAME_DONE, SYNC_ERR);
      end
      if (FRAME_DONE === 1'b1) n_done++;
      if (SYNC_ERR === 1'b1) n_sync++;
    end
  end

  // Reference model: track frame position as (row, col) and derive the address.
  task automatic model_push(input logic [15:0] d, input logic sof);
    exp_t e;
    int   row_phys;
    bit   take;
    take = 0;
    e.sync = 1'b0;
    if (sof) begin
      e.sync   = m_active;
      m_active = 1;
      m_rev    = REVERSE;
      m_col    = 0;
      m_row    = 0;
      take     = 1;
    end else if (m_active) begin
      take = 1;
    end
    if (take) begin
      row_phys = m_rev ? (VS - 1 - m_row) : m_row;
      e.addr = 4'(row_phys * HS + m_col);
      e.data = d;
      e.done = (m_col == HS - 1) && (m_row == VS - 1);
      sb.push_back(e);
      m_col++;
      if (m_col == HS) begin
        m_col = 0;
        m_row++;
        if (m_row == VS) m_active = 0;
      end
    end
  endtask

  task automatic send(input logic [15:0] d, input logic sof);
    int waited;
    bit fin;
    waited = 0;
    fin = 0;
    PIX_VALID = 1'b1;
    PIX_DATA  = d;
    PIX_SOF   = sof;
    while (!fin) begin
      @(negedge CLK);
      if (PIX_READY === 1'b1) begin
        model_push(d, sof);
        fin = 1;
      end else begin
        waited++;
        if (waited > 16) begin
          checks++;
          failures++;
          $display("FAIL ready_timeout got ready=%b exp 1 within 16 cycles", PIX_READY);
          fin = 1;
        end
      end
      @(posedge CLK);
      #1;
    end
    PIX_VALID = 1'b0;
    PIX_SOF   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string name);
    idle(3);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got pending=%0d exp 0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    idle(2);
    checks++;
    if ({BRAMWE, BRAMADDR, BRAMDIN, hcnt, vcnt, FRAME_DONE, SYNC_ERR} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got we=%b a=%0d d=%h h=%0d v=%0d fd=%b se=%b exp all 0",
               BRAMWE, BRAMADDR, BRAMDIN, hcnt, vcnt, FRAME_DONE, SYNC_ERR);
    end
    checks++;
    if (PIX_READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b exp 1", PIX_READY);
    end
    RESET_N = 1'b1;
    idle(1);
  endtask

  task automatic test_normal_frame;
    int d0;
    d0 = n_done;
    REVERSE = 1'b0;
    send(16'h0000, 1'b1);
    checks++;
    if (hcnt !== 14'd1 || vcnt !== 4'd0) begin
      failures++;
      $display("FAIL normal_first_cnt got h=%0d v=%0d exp h=1 v=0", hcnt, vcnt);
    end
    for (int i = 1; i < 12; i++) send(16'(i), 1'b0);
    checks++;
    if (PIX_READY !== 1'b0) begin
      failures++;
      $display("FAIL normal_done_ready got %b exp 0", PIX_READY);
    end
    checks++;
    if (hcnt !== 14'd0 || vcnt !== 4'd0) begin
      failures++;
      $display("FAIL normal_reload_cnt got h=%0d v=%0d exp h=0 v=0", hcnt, vcnt);
    end
    idle(1);
    checks++;
    if (PIX_READY !== 1'b1) begin
      failures++;
      $display("FAIL normal_idle_ready got %b exp 1", PIX_READY);
    end
    drain("normal");
    checks++;
    if (n_done - d0 != 1) begin
      failures++;
      $display("FAIL normal_frame_done got %0d exp 1", n_done - d0);
    end
  endtask

  task automatic test_reversed_frame;
    int d0;
    d0 = n_done;
    REVERSE = 1'b1;
    send(16'h0000, 1'b1);
    checks++;
    if (hcnt !== 14'd1 || vcnt !== 4'd8) begin
      failures++;
      $display("FAIL rev_first_cnt got h=%0d v=%0d exp h=1 v=8", hcnt, vcnt);
    end
    for (int i = 1; i < 12; i++) send(16'(i), 1'b0);
    checks++;
    if (hcnt !== 14'd0 || vcnt !== 4'd8) begin
      failures++;
      $display("FAIL rev_reload_cnt got h=%0d v=%0d exp h=0 v=8", hcnt, vcnt);
    end
    REVERSE = 1'b0;
    drain("reversed");
    checks++;
    if (n_done - d0 != 1) begin
      failures++;
      $display("FAIL rev_frame_done got %0d exp 1", n_done - d0);
    end
  endtask

  task automatic test_gaps;
    int w0;
    w0 = n_writes;
    for (int i = 0; i < 3; i++) send(16'h0F00 + 16'(i), 1'b0);
    idle(2);
    checks++;
    if (n_writes != w0) begin
      failures++;
      $display("FAIL pre_sof_writes got %0d exp 0", n_writes - w0);
    end
    send(16'h0100, 1'b1);
    for (int i = 1; i < 12; i++) begin
      idle(1);
      send(16'h0100 + 16'(i), 1'b0);
    end
    drain("gaps");
    checks++;
    if (n_writes - w0 != 12) begin
      failures++;
      $display("FAIL gaps_write_count got %0d exp 12", n_writes - w0);
    end
  endtask

  task automatic test_mid_sof;
    int s0;
    int d0;
    s0 = n_sync;
    d0 = n_done;
    send(16'h0200, 1'b1);
    for (int i = 1; i < 5; i++) send(16'h0200 + 16'(i), 1'b0);
    send(16'hAAAA, 1'b1);
    for (int i = 1; i < 12; i++) send(16'h0300 + 16'(i), 1'b0);
    drain("mid_sof");
    checks++;
    if (n_sync - s0 != 1) begin
      failures++;
      $display("FAIL mid_sof_sync_count got %0d exp 1", n_sync - s0);
    end
    checks++;
    if (n_done - d0 != 1) begin
      failures++;
      $display("FAIL mid_sof_done_count got %0d exp 1", n_done - d0);
    end
  endtask

  task automatic test_mode_toggle;
    REVERSE = 1'b0;
    send(16'h0400, 1'b1);
    for (int i = 1; i < 12; i++) begin
      if (i == 6) REVERSE = 1'b1;
      send(16'h0400 + 16'(i), 1'b0);
    end
    REVERSE = 1'b0;
    drain("mode_toggle");
  endtask

  task automatic test_reset_mid_frame;
    int d0;
    d0 = n_done;
    send(16'h0500, 1'b1);
    for (int i = 1; i < 6; i++) send(16'h0500 + 16'(i), 1'b0);
    PIX_VALID = 1'b1;
    PIX_DATA  = 16'h0506;
    @(negedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({BRAMWE, BRAMADDR, BRAMDIN, hcnt, vcnt, FRAME_DONE, SYNC_ERR} !== '0) begin
      failures++;
      $display("FAIL async_reset got we=%b a=%0d d=%h h=%0d v=%0d exp all 0",
               BRAMWE, BRAMADDR, BRAMDIN, hcnt, vcnt);
    end
    sb.delete();
    m_active = 0;
    idle(2);
    checks++;
    if ({BRAMWE, BRAMADDR, BRAMDIN, hcnt, vcnt, FRAME_DONE, SYNC_ERR} !== '0) begin
      failures++;
      $display("FAIL held_reset got we=%b a=%0d d=%h h=%0d v=%0d exp all 0",
               BRAMWE, BRAMADDR, BRAMDIN, hcnt, vcnt);
    end
    PIX_VALID = 1'b0;
    RESET_N = 1'b1;
    idle(1);
    send(16'h0507, 1'b0);
    send(16'h0600, 1'b1);
    for (int i = 1; i < 12; i++) send(16'h0600 + 16'(i), 1'b0);
    drain("reset_mid");
    checks++;
    if (n_done - d0 != 1) begin
      failures++;
      $display("FAIL reset_mid_done_count got %0d exp 1", n_done - d0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_normal_frame();
    test_reversed_frame();
    test_gaps();
    test_mid_sof();
    test_mode_toggle();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
